// File: rtl/row_bus_dispatcher_pkg.sv
// Shared types for the row-bus dispatcher and the glb_PE bus logic that sits on the same row bus.
package row_bus_pkg;

  localparam int unsigned ROW_NUM_COL   = 4;
  localparam int unsigned ROW_KS_WIDTH  = 4;
  localparam int unsigned ROW_CNT_WIDTH = 16;

  typedef logic [ROW_NUM_COL-1:0]   col_mask_t;
  typedef logic [ROW_KS_WIDTH-1:0]  ks_t;
  typedef logic [ROW_CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DONE
  } state_e;

endpackage

// File: rtl/row_bus_dispatcher_mcast_hold_reg.sv
// Multicast holding register: one data word plus a per-column pending mask,
// each bit clearing independently when its column accepts.
module mcast_hold_reg #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [NUM_COL-1:0]    mask_i,
  input  logic [NUM_COL-1:0]    ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [NUM_COL-1:0]    pending_o,
  output logic                  all_clear_next_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [NUM_COL-1:0]    pend_q, pend_d;
  logic [NUM_COL-1:0]    pend_left;

  assign pend_left        = pend_q & ~ready_i;
  assign all_clear_next_o = ~|pend_left;
  assign data_o           = data_q;
  assign pending_o        = pend_q;

  // The caller only loads when every pending bit clears this cycle, so a load never drops a handshake.
  always_comb begin
    data_d = data_q;
    pend_d = pend_left;
    if (load_i) begin
      data_d = data_i;
      pend_d = mask_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/row_bus_dispatcher.sv
// Row-bus dispatcher: latches a pass configuration, then multicasts streamed words
// to per-word column subsets with independent per-column valid/ready.
module row_bus_dispatcher
  import row_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_COL    = ROW_NUM_COL,
  parameter int unsigned KS_WIDTH   = ROW_KS_WIDTH,
  parameter int unsigned CNT_WIDTH  = ROW_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [KS_WIDTH-1:0]   cfg_kernel_size,
  input  logic [CNT_WIDTH-1:0]  cfg_num_words,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [NUM_COL-1:0]    in_col_mask,
  output logic [KS_WIDTH-1:0]   bus_kernel_size,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [NUM_COL-1:0]    bus_valid,
  input  logic [NUM_COL-1:0]    bus_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  nw_q, nw_d;
  logic [KS_WIDTH-1:0]   ks_q, ks_d;
  logic                  all_clear_next;
  logic [NUM_COL-1:0]    pending;
  logic                  in_fire;

  mcast_hold_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_COL   (NUM_COL)
  ) u_hold (
    .clk             (clk),
    .rst             (rst),
    .load_i          (in_fire),
    .data_i          (in_data),
    .mask_i          (in_col_mask),
    .ready_i         (bus_ready),
    .data_o          (bus_data),
    .pending_o       (pending),
    .all_clear_next_o(all_clear_next)
  );

  assign bus_valid       = pending;
  assign bus_kernel_size = ks_q;
  assign cfg_ready       = (state_q == ST_IDLE);
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign in_ready        = (state_q == ST_STREAM) && (cnt_q < nw_q) && all_clear_next;
  assign in_fire         = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nw_d    = nw_q;
    ks_d    = ks_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          ks_d    = cfg_kernel_size;
          nw_d    = cfg_num_words;
          cnt_d   = '0;
          state_d = (cfg_num_words != '0) ? ST_STREAM : ST_DONE;
        end
      end
      ST_STREAM: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == nw_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Tested on the registered mask, so FLUSH always lasts at least one cycle.
        if (pending == '0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      nw_q    <= '0;
      ks_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nw_q    <= nw_d;
      ks_q    <= ks_d;
    end
  end

endmodule

// File: tb/tb_row_bus_dispatcher.sv
// Scoreboard bench for row_bus_dispatcher: per-column expected-word queues fed on input
// acceptance, drained by a monitor on every bus handshake.
module tb_row_bus_dispatcher;
  import row_bus_pkg::*;

  localparam int DW = 16;
  localparam int NC = ROW_NUM_COL;
  localparam int KW = ROW_KS_WIDTH;
  localparam int CW = ROW_CNT_WIDTH;

  logic clk, rst;
  logic cfg_valid, cfg_ready;
  ks_t  cfg_kernel_size;
  cnt_t cfg_num_words;
  logic in_valid, in_ready;
  logic [DW-1:0] in_data;
  col_mask_t in_col_mask;
  ks_t  bus_kernel_size;
  logic [DW-1:0] bus_data;
  col_mask_t bus_valid, bus_ready;
  logic busy, done;

  row_bus_dispatcher #(
    .DATA_WIDTH(DW), .NUM_COL(NC), .KS_WIDTH(KW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_size(cfg_kernel_size), .cfg_num_words(cfg_num_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_col_mask(in_col_mask),
    .bus_kernel_size(bus_kernel_size), .bus_data(bus_data),
    .bus_valid(bus_valid), .bus_ready(bus_ready),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Column readiness source: fixed value, random per cycle, or column 1 toggling.
  int        rdy_mode = 0;
  col_mask_t rdy_fix  = '0;
  col_mask_t rdy_rnd  = '0;
  bit        tog      = 1'b0;
  assign bus_ready = (rdy_mode == 0) ? rdy_fix : rdy_rnd;

  always @(posedge clk) begin
    #1;
    tog = ~tog;
    if (rdy_mode == 2) rdy_rnd = {2'b00, tog, 1'b0};
    else               rdy_rnd = col_mask_t'($urandom);
  end

  // Reference model state
  bit            m_in_pass = 0;
  bit            m_drained = 0;
  int            m_n = 0, m_issued = 0, m_done_in = 0;
  ks_t           m_ks = '0;
  logic [DW-1:0] colq [NC][$];
  int            hs_cnt [NC];
  int            cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  bit            exp_inr, exp_done, cfg_acc, all_empty;
  col_mask_t     exp_bv;

  initial for (int c = 0; c < NC; c++) hs_cnt[c] = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_in_pass = 0; m_drained = 0; m_n = 0; m_issued = 0; m_done_in = 0; m_ks = '0;
      for (int c = 0; c < NC; c++) colq[c].delete();
    end else begin
      exp_inr = m_in_pass && (m_issued < m_n);
      for (int c = 0; c < NC; c++) begin
        exp_bv[c] = (colq[c].size() != 0);
        if (colq[c].size() > 1 || (colq[c].size() == 1 && !bus_ready[c])) exp_inr = 0;
      end
      exp_done = (m_done_in == 1);
      chk("cfg_ready", cfg_ready, !m_in_pass);
      chk("busy", busy, m_in_pass);
      chk("bus_kernel_size", bus_kernel_size, m_ks);
      chk("in_ready", in_ready, exp_inr);
      chk("bus_valid", bus_valid, exp_bv);
      chk("done", done, exp_done);
      if (done) done_cyc = cyc;
      cfg_acc = cfg_valid && !m_in_pass;

      for (int c = 0; c < NC; c++) begin
        if (exp_bv[c] && bus_ready[c]) begin
          chk($sformatf("bus_data_col%0d", c), bus_data, colq[c][0]);
          void'(colq[c].pop_front());
          hs_cnt[c]++;
          last_hs_cyc = cyc;
        end
      end
      if (in_valid && exp_inr) begin
        for (int c = 0; c < NC; c++) if (in_col_mask[c]) colq[c].push_back(in_data);
        m_issued++;
      end
      if (m_done_in > 0) m_done_in--;
      if (exp_done) m_in_pass = 0;
      if (cfg_acc) begin
        m_in_pass = 1;
        m_ks      = cfg_kernel_size;
        m_n       = int'(cfg_num_words);
        m_issued  = 0;
        m_drained = (m_n == 0);
        if (m_n == 0) m_done_in = 1;
      end
      all_empty = 1;
      for (int c = 0; c < NC; c++) if (colq[c].size() != 0) all_empty = 0;
      // Last word handed off (or consumed with no destinations): done two cycles later.
      if (m_in_pass && !m_drained && m_issued == m_n && all_empty) begin
        m_drained = 1;
        m_done_in = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int ks, input int n);
    bit ok = 0;
    cfg_valid = 1; cfg_kernel_size = ks_t'(ks); cfg_num_words = cnt_t'(n);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cfg_ready) begin ok = 1; break; end
    end
    if (!ok) chk("cfg_timeout", 0, 1);
    tick();
    cfg_valid = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input col_mask_t m);
    bit ok = 0;
    in_valid = 1; in_data = d; in_col_mask = m;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
    tick();
  endtask

  int b0, b1, b2, b3;

  initial begin
    rst = 1; cfg_valid = 0; cfg_kernel_size = '0; cfg_num_words = '0;
    in_valid = 0; in_data = '0; in_col_mask = '0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bus_valid", bus_valid, 0);
    tick();

    // Full multicast, all columns ready
    rdy_mode = 0; rdy_fix = 4'b1111;
    do_cfg(3, 3);
    send_word(16'h0011, 4'b1111);
    send_word(16'h0022, 4'b1111);
    send_word(16'h0033, 4'b1111);
    wait_done();
    chk("done_after_last_hs", done_cyc - last_hs_cyc, 2);

    // Staggered accept on a 0101 word
    rdy_fix = 4'b0000; b0 = hs_cnt[0]; b2 = hs_cnt[2];
    do_cfg(3, 1);
    send_word(16'h00A5, 4'b0101);
    rdy_fix = 4'b0001; tick();
    rdy_fix = 4'b0000; tick(); tick();
    rdy_fix = 4'b0100; tick();
    rdy_fix = 4'b0000;
    wait_done();
    chk("stagger_col0_once", hs_cnt[0] - b0, 1);
    chk("stagger_col2_once", hs_cnt[2] - b2, 1);

    // Zero mask word, then a zero-length pass
    rdy_fix = 4'b1111; b0 = hs_cnt[0]; b1 = hs_cnt[1]; b2 = hs_cnt[2]; b3 = hs_cnt[3];
    do_cfg(2, 2);
    send_word(16'h1234, 4'b0000);
    send_word(16'h5678, 4'b0010);
    wait_done();
    chk("zmask_col1", hs_cnt[1] - b1, 1);
    chk("zmask_others", (hs_cnt[0] - b0) + (hs_cnt[2] - b2) + (hs_cnt[3] - b3), 0);
    do_cfg(2, 0);
    wait_done();

    // Config lockout during a pass
    rdy_fix = 4'b0000;
    do_cfg(3, 1);
    send_word(16'h0BEE, 4'b0001);
    cfg_valid = 1; cfg_kernel_size = 4'd5; cfg_num_words = 16'd7;
    repeat (3) tick();
    chk("lockout_ks", bus_kernel_size, 3);
    cfg_valid = 0; rdy_fix = 4'b0001;
    wait_done();
    do_cfg(5, 0);
    chk("new_cfg_ks", bus_kernel_size, 5);
    wait_done();

    // Backpressure on column 1 with toggling ready and input stalls
    rdy_mode = 2; b1 = hs_cnt[1];
    do_cfg(4, 8);
    for (int w = 0; w < 8; w++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_word(DW'($urandom), 4'b0010);
    end
    wait_done();
    chk("bp_col1_hs", hs_cnt[1] - b1, 8);

    // Reset mid-pass with a word still held
    rdy_mode = 0; rdy_fix = 4'b1111;
    do_cfg(3, 4);
    send_word(16'h0101, 4'b1111);
    send_word(16'h0202, 4'b1111);
    rdy_fix = 4'b0000;
    rst = 1; tick(); rst = 0;
    @(negedge clk);
    chk("midrst_bus_valid", bus_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cfg_ready", cfg_ready, 1);
    chk("midrst_ks", bus_kernel_size, 0);
    tick();

    // Randomized passes
    rdy_mode = 1;
    for (int p = 0; p < 25; p++) begin
      int n;
      n = $urandom_range(1, 10);
      do_cfg($urandom_range(0, 15), n);
      for (int w = 0; w < n; w++) begin
        col_mask_t m;
        repeat ($urandom_range(0, 2)) tick();
        m = col_mask_t'($urandom);
        if ($urandom_range(0, 4) == 0) m = '0;
        send_word(DW'($urandom), m);
      end
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
